// File: rtl/interleaved_mod_mult.sv
// interleaved_mod_mult
//   Sequential K-bit modular multiplier, C = (A * B) mod M, computed MSB-first
//   by interleaved shift-and-add with one conditional subtraction per step.
//   One multiplier bit is processed per cycle, so the latency from the accept
//   edge to the result is K cycles. Twiddle-multiply stage of the NTT butterfly.
//
// Optional feature macro: MODMUL_CHECK_EN
//   When defined, adds the err output. At accept, the operands are rejected
//   if M == 0 or A >= M. A rejected operation returns C = 0 with err = 1
//   one cycle after accept.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   A/B/M valid
//   in_ready   out  ready for a new operand set (IDLE only)
//   A          in   K  multiplicand, A < M
//   B          in   K  multiplier
//   M          in   K  modulus, 1 <= M
//   out_valid  out  C valid
//   out_ready  in   downstream accepts C
//   C          out  K  registered result
//   err        out  operand check failed (MODMUL_CHECK_EN only)
module interleaved_mod_mult #(
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  input  logic [K-1:0] M,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef MODMUL_CHECK_EN
  output logic         err,
`endif
  output logic [K-1:0] C
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [K-1:0]  a_r, b_r, m_r;
  logic [K:0]    p;
  logic [CW-1:0] cnt;
  logic [K-1:0]  c_q;
  logic          accept;
  logic          bad;

  // Datapath for one step, all K+1 bits wide.
  logic [K:0] a_ext, m_ext, t2, t, u_add, u;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign C         = c_q;
  assign accept    = in_valid && (state_q == IDLE);

`ifdef MODMUL_CHECK_EN
  logic err_q;
  assign err = err_q;
  assign bad = (M == '0) || (A >= M);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    a_ext = {1'b0, a_r};
    m_ext = {1'b0, m_r};
    // P < M < 2^K, so P's top bit is zero and the shift cannot lose a bit.
    t2    = {p[K-1:0], 1'b0};
    t     = (t2 >= m_ext) ? (t2 - m_ext) : t2;
    u_add = t + a_ext;
    u     = t;
    if (b_r[cnt]) begin
      u = (u_add >= m_ext) ? (u_add - m_ext) : u_add;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = bad ? DONE : RUN;
      RUN:  if (cnt == '0) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      m_r   <= '0;
      p     <= '0;
      cnt   <= '0;
      c_q   <= '0;
`ifdef MODMUL_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_r <= A;
        b_r <= B;
        m_r <= M;
        p   <= '0;
        cnt <= CW'(K - 1);
`ifdef MODMUL_CHECK_EN
        err_q <= bad;
        if (bad) c_q <= '0;
`endif
      end else if (state_q == RUN) begin
        p <= u;
        if (cnt == '0) begin
          c_q <= u[K-1:0];
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/interleaved_mod_mult.md
# interleaved_mod_mult

Sequential K-bit modular multiplier computing C = (A · B) mod M by MSB-first interleaved shift-and-add with one-step conditional subtraction. It is the twiddle-multiply stage of the NTT butterfly. It sits directly upstream of the modular adder/subtractor: its product W·x feeds that adder's B operand. It processes one multiplier bit per cycle and uses valid/ready handshakes on both sides.

## Interface
- K, default 8: operand and modulus width in bits.
- clk  input  1: clock; all state updates on the rising edge.
- rst_n  input  1: reset, asynchronous assert and active-low; state is released synchronously on the clk edge.
- in_valid  input  1: A, B and M are valid.
- in_ready  output  1: block accepts a new operand set; high only in IDLE.
- A  input  K: multiplicand; must satisfy A < M.
- B  input  K: multiplier; any K-bit value.
- M  input  K: modulus; must satisfy 1 ≤ M ≤ 2^K−1.
- out_valid  output  1: C holds a valid result.
- out_ready  input  1: the downstream stage accepts C.
- C  output  K: result (A·B) mod M, registered.
- err  output  1: present only with MODMUL_CHECK_EN (see Configuration).

## Operation
- Three states: IDLE, RUN, DONE. Reset puts the block in IDLE with C=0, out_valid=0 and err=0; in_ready=1 follows from IDLE.
- IDLE:
  - On in_valid && in_ready, capture A, B and M into internal registers.
  - Clear the partial product P (K+1 bits) to 0 and set the bit counter cnt to K−1.
  - Go to RUN.
- RUN: each cycle processes bit B[cnt].
  - T = 2P. If T ≥ M, then T = T − M.
  - If B[cnt]=1: U = T + A, and if U ≥ M, then U = U − M. Otherwise U = T.
  - P ← U.
  - If cnt = 0, load C ← U[K−1:0] and go to DONE; otherwise cnt ← cnt − 1.
- DONE: out_valid=1 and C is held stable. On out_ready=1, go to IDLE.
- Arithmetic width rules:
  - All intermediates are K+1 bits unsigned.
  - The invariant P < M holds throughout, so 2P < 2M ≤ 2^(K+1) and T+A < 2M. One conditional subtraction per step is always sufficient, and no intermediate overflows K+1 bits.
- Inputs are ignored outside IDLE. A, B and M may change freely after the accept edge.
- Reset asserted in any state, including mid-RUN or DONE with a pending out_valid:
  - Immediately forces IDLE, out_valid=0, C=0 and err=0.
  - The in-flight operation is discarded and is not resumed.

## Timing
- Accept occurs at edge e0. RUN updates occur at edges e1..eK.
- out_valid rises after edge eK, giving a latency of K cycles from the accept edge to the result.
- The handshake completes at the first edge where out_valid && out_ready. in_ready is high from the following cycle.
- Minimum interval between accepts is K+2 cycles.
- With out_ready held high, out_valid is high for exactly one cycle.
- With backpressure, C and out_valid hold indefinitely, and in_ready stays low.
- in_ready and out_valid are never high in the same cycle.

## Configuration
- Macro MODMUL_CHECK_EN.
- When defined:
  - The err port exists.
  - At accept, the block checks M == 0 or A ≥ M. If the check fails, it skips RUN and goes directly to DONE on the next edge with C=0 and err=1.
  - err is valid with out_valid and is cleared when the next operation is accepted.
  - A valid operation is checked but otherwise unchanged: latency K, err=0.
- When undefined:
  - No err port and no input checking.
  - Latency is always K cycles.
  - C is unspecified for inputs that violate A < M or M ≥ 1.

## Test plan
- K=8, M=251, A=200, B=150, out_ready=1 -> C=131 and out_valid after exactly 8 cycles, high for 1 cycle; in_ready high the next cycle.
- M=251, A=250, B=255 -> C=247. M=251, A=0, B=255 -> C=0. M=251, A=17, B=0 -> C=0.
- M=255, A=254, B=255 -> C=0 (because 254·255 = 254·255 mod 255 = 0). M=1, A=0, B=200 -> C=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - C and out_valid stay stable and in_ready stays 0.
  - A new in_valid during the stall is ignored.
  - Release out_ready -> one handshake, then IDLE.
- Reset pulse mid-RUN (at cycle 4 of 8):
  - out_valid=0, C=0 and in_ready=1 immediately.
  - The next operation (M=251, A=200, B=150) yields 131 with full latency.
- MODMUL_CHECK_EN: M=0 or A=251 with M=251 -> out_valid 1 cycle after accept, C=0, err=1. A following valid operation -> err=0 and the correct result.
